codec_cfg_sequencer: RTL
========================

Name: codec_cfg_sequencer

Overview:
- Byte-level controller that sequences the I2C byte engine to program the audio codec's control registers.
- After reset or on an `init_start` pulse, it walks an init table of 16-bit register words. Each word is sent as START, device-address byte, high byte, low byte, STOP.
- After init completes, it accepts runtime register writes, e.g. volume or mute, through a valid/ready port.
- It handles NACK retry and engine-stall timeout, and reports done/error status to the deck control logic.

Parameters:
- DEV_ADDR, 7'h1A: codec 7-bit I2C address. The transmitted byte is {DEV_ADDR, 1'b0}.
- INIT_LEN, 10: number of init table entries, range 1..64.
- MAX_RETRIES, 3: retries per transaction after NACK, range 0..15.
- TIMEOUT_CYCLES, 20'd100000: clk cycles allowed between issuing an engine step and receiving `eng_done`.
- GAP_CYCLES, 16'd64: idle bus cycles inserted after each STOP.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- init_start, in, 1: pulse that restarts the init sequence from entry 0. Ignored while busy.
- wr_valid, in, 1: runtime write request.
- wr_word, in, 16: {reg_addr[6:0], data[8:0]}.
- wr_ready, out, 1: high only in IDLE after `init_done`. A write is accepted when wr_valid && wr_ready.
- eng_op, out, 2: to engine. 0 = IDLE, 1 = WRITE. READ is never issued.
- eng_cond, out, 2: to engine. 0 = none, 1 = START, 2 = STOP.
- eng_wdata, out, 8: byte to transmit.
- eng_done, in, 1: one-cycle pulse when the current byte (including the ack slot) or condition completes.
- eng_ack, in, 1: SDA sampled in the ack slot. 1 = NACK. Valid in the cycle `eng_done` is high for a byte.
- rom_idx, out, 6: init table index.
- rom_word, in, 16: combinational table data for `rom_idx`.
- busy, out, 1: high in any state other than IDLE, DONE_IDLE or ERROR.
- init_done, out, 1: sticky; set when the last init entry is ACKed.
- error, out, 1: sticky; set on retry exhaustion or timeout.
- err_idx, out, 6: init index, or 6'h3F for a runtime write, of the failing transaction.

Behaviour:
- Reset:
  - eng_op = 0, eng_cond = 0, eng_wdata = 8'h00, rom_idx = 0.
  - busy = 0, init_done = 0, error = 0, err_idx = 0, wr_ready = 0.
  - Leaving reset, the FSM enters LOAD with idx = 0. Init is automatic, with no `init_start` needed.
  - Reset mid-transaction aborts immediately: outputs go to reset values and no STOP is sent. Recovery is the next START.
- FSM states:
  - IDLE, LOAD, START, DEV, HI, LO, STOP, GAP, ERROR.
  - A step state drives its eng_op/eng_cond/eng_wdata and holds them constant until `eng_done`. It then moves on in the next cycle.
- LOAD: latches a txn register from `rom_word` (init) or `wr_word` (runtime). Clears the retry count, then goes to START.
- Byte mapping:
  - START uses cond = 1.
  - DEV sends {DEV_ADDR, 0}.
  - HI sends txn[15:8].
  - LO sends txn[7:0].
  - STOP uses cond = 2.
- NACK handling:
  - eng_ack = 1 with `eng_done` in DEV, HI or LO goes to STOP, then GAP, then retry from START if retries < MAX_RETRIES.
  - Otherwise it sets `error` and `err_idx`, sends STOP and parks in ERROR.
- Successful STOP goes to GAP.
  - GAP counts GAP_CYCLES, then increments idx.
  - If idx == INIT_LEN-1 was just done, set `init_done` and go to IDLE. Otherwise go to LOAD.
  - A runtime write finishing GAP goes to IDLE.
- Timeout:
  - A watchdog clears on every state entry and counts while waiting for `eng_done`.
  - Reaching TIMEOUT_CYCLES sets `error`, forces eng_op = 0 and eng_cond = 0, and goes to ERROR.
  - An `eng_done` arriving in the same cycle as the timeout takes precedence.
- ERROR: exited only by `init_start`, which clears `error` and `init_done` and restarts at idx 0.
- IDLE:
  - `init_start` has priority over `wr_valid` in the same cycle. The write is not accepted and `wr_ready` drops.
  - `wr_ready` is combinational from state and `init_done`.
- The idx counter is 6-bit and never wraps past INIT_LEN-1.
- `eng_done` is ignored in IDLE, LOAD and GAP.

Decomposition:
- Package codec_cfg_pkg holds:
  - the engine op/cond encodings;
  - the FSM state enum;
  - the txn word field slices (reg_addr = [15:9], data = [8:0]).
- Sub-module codec_init_rom holds the combinational init table: rom_idx in, rom_word out, INIT_LEN entries. It covers reset, power-down, format, sample rate and active registers.

Test Plan:
- Reset release with an always-ACK engine model:
  - The bench sees INIT_LEN transactions, each in order START, 8'h34, HI, LO, STOP.
  - init_done = 1, busy = 0 and wr_ready = 1 afterwards.
- NACK on the HI byte of entry 3, twice, then ACK:
  - Two STOP/GAP/retry cycles, then entry 3 completes and entry 4 follows.
  - error stays 0.
- Persistent NACK on the DEV byte with MAX_RETRIES = 3:
  - Four attempts, each followed by STOP.
  - error = 1, err_idx = 0, state ERROR.
  - `init_start` then restarts from idx 0.
- Engine never pulses `eng_done` in HI, with TIMEOUT_CYCLES = 50:
  - error = 1 exactly 50 cycles after HI entry.
  - eng_op = 0 and eng_cond = 0.
- Runtime write wr_word = 16'h0C79 after init:
  - Accepted in one cycle.
  - Bytes 8'h34, 8'h0C, 8'h79 are sent, then wr_ready returns after GAP.
- Reset asserted mid-LO byte:
  - All outputs take reset values on the next edge.
  - Init restarts at idx 0.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// Shared definitions for the codec configuration sequencer: I2C byte-engine
// encodings, FSM state codes and the layout of a 16-bit codec register word.
package codec_cfg_pkg;

    // Byte-engine operation (READ exists on the engine but is never issued here)
    typedef enum logic [1:0] {
        ENG_OP_IDLE  = 2'd0,
        ENG_OP_WRITE = 2'd1,
        ENG_OP_READ  = 2'd2
    } eng_op_e;

    // Bus condition requested from the byte engine
    typedef enum logic [1:0] {
        ENG_COND_NONE  = 2'd0,
        ENG_COND_START = 2'd1,
        ENG_COND_STOP  = 2'd2
    } eng_cond_e;

    // Sequencer FSM state codes
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_LOAD  = 4'd1;
    localparam state_t ST_START = 4'd2;
    localparam state_t ST_DEV   = 4'd3;
    localparam state_t ST_HI    = 4'd4;
    localparam state_t ST_LO    = 4'd5;
    localparam state_t ST_STOP  = 4'd6;
    localparam state_t ST_GAP   = 4'd7;
    localparam state_t ST_ERROR = 4'd8;

    // Codec register word: 7-bit register address followed by 9-bit data
    typedef struct packed {
        logic [6:0] reg_addr;  // bits [15:9]
        logic [8:0] data;      // bits [8:0]
    } txn_t;

    // err_idx value reported when a runtime write (not an init entry) fails
    localparam logic [5:0] RUNTIME_ERR_IDX = 6'h3F;

    function automatic txn_t make_txn(input logic [6:0] reg_addr, input logic [8:0] data);
        txn_t t;
        t.reg_addr = reg_addr;
        t.data     = data;
        return t;
    endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Combinational codec init table: reset, power-down, line-in, headphone,
// analogue/digital path, format, sample rate and finally activate.
module codec_init_rom
    import codec_cfg_pkg::*;
#(
    parameter int INIT_LEN = 10
) (
    input  logic [5:0]  rom_idx,
    output logic [15:0] rom_word
);

    localparam logic [6:0] REG_LLINE   = 7'h00;
    localparam logic [6:0] REG_RLINE   = 7'h01;
    localparam logic [6:0] REG_LHP     = 7'h02;
    localparam logic [6:0] REG_ANALOG  = 7'h04;
    localparam logic [6:0] REG_DIGITAL = 7'h05;
    localparam logic [6:0] REG_POWER   = 7'h06;
    localparam logic [6:0] REG_FORMAT  = 7'h07;
    localparam logic [6:0] REG_RATE    = 7'h08;
    localparam logic [6:0] REG_ACTIVE  = 7'h09;
    localparam logic [6:0] REG_RESET   = 7'h0F;

    txn_t entry;

    // Table lookup; indices at or beyond INIT_LEN are never addressed and read as zero
    always_comb begin
        // NOTE: assign a default before the case so every path drives entry and no latch is inferred
        entry = '0;
        case (rom_idx)
            6'd0:    entry = make_txn(REG_RESET,   9'h000);  // soft reset
            6'd1:    entry = make_txn(REG_POWER,   9'h010);  // power up all but outputs
            6'd2:    entry = make_txn(REG_LLINE,   9'h017);  // left line-in 0 dB
            6'd3:    entry = make_txn(REG_RLINE,   9'h017);  // right line-in 0 dB
            6'd4:    entry = make_txn(REG_LHP,     9'h079);  // headphone 0 dB
            6'd5:    entry = make_txn(REG_ANALOG,  9'h012);  // DAC select, line-in to ADC
            6'd6:    entry = make_txn(REG_DIGITAL, 9'h000);  // no de-emphasis, unmuted
            6'd7:    entry = make_txn(REG_FORMAT,  9'h042);  // I2S, 16-bit, master
            6'd8:    entry = make_txn(REG_RATE,    9'h000);  // 48 kHz normal mode
            6'd9:    entry = make_txn(REG_ACTIVE,  9'h001);  // activate interface
            default: entry = '0;
        endcase
        if (int'(rom_idx) >= INIT_LEN) entry = '0;
    end

    assign rom_word = entry;

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Sequences the I2C byte engine to write the codec init table after reset or
// init_start, then serves runtime register writes. Each word goes out as
// START, device address, high byte, low byte, STOP, followed by a bus gap.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = 7'h1A,
    parameter int          INIT_LEN       = 10,
    parameter int          MAX_RETRIES    = 3,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000,
    parameter logic [15:0] GAP_CYCLES     = 16'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_start,
    input  logic        wr_valid,
    input  logic [15:0] wr_word,
    output logic        wr_ready,
    output logic [1:0]  eng_op,
    output logic [1:0]  eng_cond,
    output logic [7:0]  eng_wdata,
    input  logic        eng_done,
    input  logic        eng_ack,
    output logic [5:0]  rom_idx,
    input  logic [15:0] rom_word,
    output logic        busy,
    output logic        init_done,
    output logic        error,
    output logic [5:0]  err_idx
);

    localparam logic [19:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 20'd1;
    localparam logic [19:0] GAP_LAST     = {4'd0, GAP_CYCLES} - 20'd1;
    localparam logic [5:0]  LAST_IDX     = 6'(INIT_LEN - 1);
    localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

    state_t      state, state_nx;
    logic [5:0]  idx;
    txn_t        txn;
    logic        rt_mode;        // current transaction is a runtime write
    logic [3:0]  retry_cnt;
    logic        retry_pending;  // GAP must restart the same word from START
    logic        fail_pending;   // STOP must park in ERROR
    logic [19:0] cnt;            // watchdog in step states, gap length in GAP
    logic        step_st;
    logic        timeout;
    logic [5:0]  cur_idx;

    assign step_st  = (state == ST_START) || (state == ST_DEV) || (state == ST_HI) ||
                      (state == ST_LO)    || (state == ST_STOP);
    // A completion in the same cycle wins over the watchdog
    assign timeout  = step_st && !eng_done && (cnt == TIMEOUT_LAST);
    assign cur_idx  = rt_mode ? RUNTIME_ERR_IDX : idx;
    assign wr_ready = (state == ST_IDLE) && init_done && !init_start;
    assign busy     = (state != ST_IDLE) && (state != ST_ERROR);
    assign rom_idx  = idx;

    // Next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (init_start || !init_done || (wr_valid && wr_ready)) state_nx = ST_LOAD;
            ST_LOAD:  state_nx = ST_START;
            ST_START: if (eng_done) state_nx = ST_DEV;
                      else if (timeout) state_nx = ST_ERROR;
            ST_DEV:   if (eng_done) state_nx = eng_ack ? ST_STOP : ST_HI;
                      else if (timeout) state_nx = ST_ERROR;
            ST_HI:    if (eng_done) state_nx = eng_ack ? ST_STOP : ST_LO;
                      else if (timeout) state_nx = ST_ERROR;
            ST_LO:    if (eng_done) state_nx = ST_STOP;
                      else if (timeout) state_nx = ST_ERROR;
            ST_STOP:  if (eng_done) state_nx = fail_pending ? ST_ERROR : ST_GAP;
                      else if (timeout) state_nx = ST_ERROR;
            ST_GAP:   if (cnt == GAP_LAST) begin
                          if (retry_pending)                     state_nx = ST_START;
                          else if (rt_mode || idx == LAST_IDX)   state_nx = ST_IDLE;
                          else                                   state_nx = ST_LOAD;
                      end
            ST_ERROR: if (init_start) state_nx = ST_LOAD;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // State, counters, transaction word and sticky status
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= '0;
            txn           <= '0;
            rt_mode       <= 1'b0;
            retry_cnt     <= '0;
            retry_pending <= 1'b0;
            fail_pending  <= 1'b0;
            cnt           <= '0;
            init_done     <= 1'b0;
            error         <= 1'b0;
            err_idx       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values
            state <= state_nx;
            if (state_nx != state)              cnt <= '0;
            else if (step_st || state == ST_GAP) cnt <= cnt + 20'd1;

            if (timeout) begin
                error   <= 1'b1;
                err_idx <= cur_idx;
            end

            case (state)
                ST_IDLE: begin
                    if (init_start || !init_done) begin
                        idx       <= '0;
                        rt_mode   <= 1'b0;
                        init_done <= 1'b0;
                    end else if (wr_valid && wr_ready) begin
                        txn     <= wr_word;
                        rt_mode <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!rt_mode) txn <= rom_word;
                    retry_cnt     <= '0;
                    retry_pending <= 1'b0;
                    fail_pending  <= 1'b0;
                end
                ST_DEV, ST_HI, ST_LO: begin
                    if (eng_done && eng_ack) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt     <= retry_cnt + 4'd1;
                            retry_pending <= 1'b1;
                        end else begin
                            error        <= 1'b1;
                            err_idx      <= cur_idx;
                            fail_pending <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        if (retry_pending) begin
                            retry_pending <= 1'b0;
                        end else if (!rt_mode) begin
                            if (idx == LAST_IDX) init_done <= 1'b1;
                            else                 idx       <= idx + 6'd1;
                        end
                    end
                end
                ST_ERROR: begin
                    if (init_start) begin
                        error     <= 1'b0;
                        init_done <= 1'b0;
                        idx       <= '0;
                        rt_mode   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Engine command for the current step, held until eng_done moves the FSM on
    always_comb begin
        eng_op    = ENG_OP_IDLE;
        eng_cond  = ENG_COND_NONE;
        eng_wdata = 8'h00;
        case (state)
            ST_START: eng_cond = ENG_COND_START;
            ST_DEV: begin
                eng_op    = ENG_OP_WRITE;
                eng_wdata = {DEV_ADDR, 1'b0};
            end
            ST_HI: begin
                eng_op    = ENG_OP_WRITE;
                eng_wdata = txn[15:8];
            end
            ST_LO: begin
                eng_op    = ENG_OP_WRITE;
                eng_wdata = txn[7:0];
            end
            ST_STOP: eng_cond = ENG_COND_STOP;
            default: ;
        endcase
    end

endmodule
